// File: rtl/rl_table_bank_if.sv
// Bus for the Q-learning table bank: read/write ports for the Q and Qmax tables,
// the R ROM read port, and the ready flag.
interface rl_table_bank_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SADDR_WIDTH = 6,
    parameter int DATA_WIDTH  = 8
);
    logic                   ready;
    logic [ADDR_WIDTH-1:0]  q_addr_r;
    logic [ADDR_WIDTH-1:0]  q_addr_w;
    logic                   q_read_en;
    logic                   q_write_en;
    logic [DATA_WIDTH-1:0]  q_wdata;
    logic [DATA_WIDTH-1:0]  q_rdata;
    logic [SADDR_WIDTH-1:0] qmax_addr_r;
    logic [SADDR_WIDTH-1:0] qmax_addr_w;
    logic                   qmax_read_en;
    logic                   qmax_write_en;
    logic [DATA_WIDTH-1:0]  qmax_wdata;
    logic [DATA_WIDTH-1:0]  qmax_rdata;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_read;
    logic [DATA_WIDTH-1:0]  r_rdata;

    modport master (
        input  ready, q_rdata, qmax_rdata, r_rdata,
        output q_addr_r, q_addr_w, q_read_en, q_write_en, q_wdata,
               qmax_addr_r, qmax_addr_w, qmax_read_en, qmax_write_en, qmax_wdata,
               r_addr, r_read
    );

    modport slave (
        output ready, q_rdata, qmax_rdata, r_rdata,
        input  q_addr_r, q_addr_w, q_read_en, q_write_en, q_wdata,
               qmax_addr_r, qmax_addr_w, qmax_read_en, qmax_write_en, qmax_wdata,
               r_addr, r_read
    );
endinterface

// File: rtl/rl_table_bank.sv
// Q-learning storage bank: Q and Qmax dual-port RAMs cleared by a post-reset sweep,
// plus a constant reward ROM. All accesses are gated until the sweep finishes.
module rl_table_bank #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    SADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] GOAL_REWARD = 8'h10
) (
    input  logic           clk,
    input  logic           rst_n,
    rl_table_bank_if.slave bus
);
    localparam int Q_DEPTH    = 1 << ADDR_WIDTH;
    localparam int QMAX_DEPTH = 1 << SADDR_WIDTH;

    logic [DATA_WIDTH-1:0] q_mem    [Q_DEPTH];
    logic [DATA_WIDTH-1:0] qmax_mem [QMAX_DEPTH];

    logic [ADDR_WIDTH-1:0] sweep_cnt_reg;
    logic                  ready_reg;

    logic [DATA_WIDTH-1:0] q_rdata_reg;
    logic [DATA_WIDTH-1:0] qmax_rdata_reg;
    logic [DATA_WIDTH-1:0] r_rdata_reg;

    logic                   q_we;
    logic [ADDR_WIDTH-1:0]  q_waddr;
    logic [DATA_WIDTH-1:0]  q_wdata;
    logic                   qmax_we;
    logic [SADDR_WIDTH-1:0] qmax_waddr;
    logic [DATA_WIDTH-1:0]  qmax_wdata;
    logic                   r_goal;

    // Sweep counter walks the Q address space once after every reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt_reg <= '0;
            ready_reg     <= 1'b0;
        end else if (!ready_reg) begin
            sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
            if (&sweep_cnt_reg)
                ready_reg <= 1'b1;
        end
    end

    // The sweep owns the write ports until ready; Qmax only spans the low states.
    always_comb begin
        q_we       = 1'b0;
        q_waddr    = sweep_cnt_reg;
        q_wdata    = '0;
        qmax_we    = 1'b0;
        qmax_waddr = sweep_cnt_reg[SADDR_WIDTH-1:0];
        qmax_wdata = '0;
        if (ready_reg) begin
            q_we       = bus.q_write_en;
            q_waddr    = bus.q_addr_w;
            q_wdata    = bus.q_wdata;
            qmax_we    = bus.qmax_write_en;
            qmax_waddr = bus.qmax_addr_w;
            qmax_wdata = bus.qmax_wdata;
        end else begin
            q_we    = 1'b1;
            qmax_we = (sweep_cnt_reg[ADDR_WIDTH-1:SADDR_WIDTH] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (q_we)
            q_mem[q_waddr] <= q_wdata;
        if (qmax_we)
            qmax_mem[qmax_waddr] <= qmax_wdata;
    end

    // Only state 6'b111111 in action slot 0 of the address map carries the goal reward.
    assign r_goal = (bus.r_addr[SADDR_WIDTH-1:0] == '1) &&
                    (bus.r_addr[ADDR_WIDTH-1:SADDR_WIDTH] == '0);

    // Read registers sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_rdata_reg    <= '0;
            qmax_rdata_reg <= '0;
            r_rdata_reg    <= '0;
        end else if (ready_reg) begin
            if (bus.q_read_en)
                q_rdata_reg <= q_mem[bus.q_addr_r];
            if (bus.qmax_read_en)
                qmax_rdata_reg <= qmax_mem[bus.qmax_addr_r];
            if (bus.r_read)
                r_rdata_reg <= r_goal ? GOAL_REWARD : '0;
        end
    end

    assign bus.ready      = ready_reg;
    assign bus.q_rdata    = q_rdata_reg;
    assign bus.qmax_rdata = qmax_rdata_reg;
    assign bus.r_rdata    = r_rdata_reg;
endmodule

// File: tb/tb_rl_table_bank.sv
// Self-checking bench for rl_table_bank: directed vector table, reset/sweep
// sequences, and randomized traffic against a table-level reference model.
module tb_rl_table_bank;
    logic clk;
    logic rst_n;

    rl_table_bank_if #(.ADDR_WIDTH(8), .SADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();

    rl_table_bank #(
        .ADDR_WIDTH(8), .SADDR_WIDTH(6), .DATA_WIDTH(8), .GOAL_REWARD(8'h10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain table contents plus the last value shown on each output.
    logic [7:0] m_q    [256];
    logic [7:0] m_qmax [64];
    logic [7:0] m_q_out, m_qmax_out, m_r_out;

    typedef struct {
        logic       q_we;   logic [7:0] q_wa;  logic [7:0] q_wd;
        logic       q_re;   logic [7:0] q_ra;
        logic       m_we;   logic [5:0] m_wa;  logic [7:0] m_wd;
        logic       m_re;   logic [5:0] m_ra;
        logic       r_re;   logic [7:0] r_a;
        logic [7:0] exp_q;  logic [7:0] exp_m; logic [7:0] exp_r;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] r_ref(input logic [7:0] a);
        return (a == 8'h3F) ? 8'h10 : 8'h00;
    endfunction

    task automatic idle_inputs();
        bus.q_read_en = 0;  bus.q_write_en = 0;  bus.q_addr_r = 0;  bus.q_addr_w = 0;  bus.q_wdata = 0;
        bus.qmax_read_en = 0; bus.qmax_write_en = 0; bus.qmax_addr_r = 0; bus.qmax_addr_w = 0;
        bus.qmax_wdata = 0; bus.r_read = 0; bus.r_addr = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_q[i] = 8'h00;
        for (int i = 0; i < 64; i++)  m_qmax[i] = 8'h00;
        m_q_out = 0; m_qmax_out = 0; m_r_out = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction, clock it, and advance the model (reads see pre-write contents).
    task automatic apply(input vec_t v);
        bus.q_write_en = v.q_we;  bus.q_addr_w = v.q_wa;  bus.q_wdata = v.q_wd;
        bus.q_read_en  = v.q_re;  bus.q_addr_r = v.q_ra;
        bus.qmax_write_en = v.m_we; bus.qmax_addr_w = v.m_wa; bus.qmax_wdata = v.m_wd;
        bus.qmax_read_en  = v.m_re; bus.qmax_addr_r = v.m_ra;
        bus.r_read = v.r_re; bus.r_addr = v.r_a;
        cyc();
        if (v.q_re) m_q_out    = m_q[v.q_ra];
        if (v.m_re) m_qmax_out = m_qmax[v.m_ra];
        if (v.r_re) m_r_out    = r_ref(v.r_a);
        if (v.q_we) m_q[v.q_wa]    = v.q_wd;
        if (v.m_we) m_qmax[v.m_wa] = v.m_wd;
        idle_inputs();
    endtask

    function automatic vec_t mk(input logic q_we, input logic [7:0] q_wa, input logic [7:0] q_wd,
                                input logic q_re, input logic [7:0] q_ra,
                                input logic m_we, input logic [5:0] m_wa, input logic [7:0] m_wd,
                                input logic m_re, input logic [5:0] m_ra,
                                input logic r_re, input logic [7:0] r_a,
                                input logic [7:0] eq, input logic [7:0] em, input logic [7:0] er);
        vec_t v;
        v.q_we = q_we; v.q_wa = q_wa; v.q_wd = q_wd; v.q_re = q_re; v.q_ra = q_ra;
        v.m_we = m_we; v.m_wa = m_wa; v.m_wd = m_wd; v.m_re = m_re; v.m_ra = m_ra;
        v.r_re = r_re; v.r_a = r_a; v.exp_q = eq; v.exp_m = em; v.exp_r = er;
        return v;
    endfunction

    // Release reset and check ready is low for exactly 256 edges, optionally strobing
    // writes/reads during the sweep to late-swept-past addresses.
    task automatic sweep_check(input bit strobe);
        for (int e = 1; e <= 256; e++) begin
            if (strobe && e >= 20 && e < 40) begin
                bus.q_write_en = 1; bus.q_addr_w = 8'h05; bus.q_wdata = 8'h77;
                bus.q_read_en = 1;  bus.q_addr_r = 8'h05;
                bus.qmax_write_en = 1; bus.qmax_addr_w = 6'h02; bus.qmax_wdata = 8'h66;
                bus.qmax_read_en = 1;  bus.qmax_addr_r = 6'h02;
                bus.r_read = 1; bus.r_addr = 8'h3F;
            end else begin
                idle_inputs();
            end
            cyc();
            if (e == 39 && strobe) begin
                chk("sweep_q_out", bus.q_rdata, 8'h00);
                chk("sweep_qmax_out", bus.qmax_rdata, 8'h00);
                chk("sweep_r_out", bus.r_rdata, 8'h00);
            end
            if (e == 255) chk("ready_low_255", {7'd0, bus.ready}, 8'h00);
            if (e == 256) chk("ready_high_256", {7'd0, bus.ready}, 8'h01);
        end
        idle_inputs();
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!bus.ready && n < budget) begin cyc(); n++; end
        chk("wait_ready", {7'd0, bus.ready}, 8'h01);
    endtask

    initial begin
        idle_inputs();
        model_clear();
        rst_n = 1'b0;
        #23;
        chk("rst_q", bus.q_rdata, 8'h00);
        chk("rst_qmax", bus.qmax_rdata, 8'h00);
        chk("rst_r", bus.r_rdata, 8'h00);
        chk("rst_ready", {7'd0, bus.ready}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check(1'b0);

        // Directed table: {q wr, q rd, qmax wr, qmax rd, r rd} -> expected outputs.
        vecs.push_back(mk(0,8'h00,8'h00, 1,8'hFF, 0,6'h00,8'h00, 1,6'h3F, 0,8'h00, 8'h00,8'h00,8'h00));
        vecs.push_back(mk(1,8'h85,8'h3C, 0,8'h00, 0,6'h00,8'h00, 0,6'h00, 0,8'h00, 8'h00,8'h00,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 1,8'h85, 0,6'h00,8'h00, 0,6'h00, 0,8'h00, 8'h3C,8'h00,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,6'h00,8'h00, 0,6'h00, 0,8'h00, 8'h3C,8'h00,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 1,6'h21,8'h20, 0,6'h00, 0,8'h00, 8'h3C,8'h00,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,6'h00,8'h00, 1,6'h21, 0,8'h00, 8'h3C,8'h20,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 1,6'h21,8'h30, 1,6'h21, 0,8'h00, 8'h3C,8'h20,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,6'h00,8'h00, 1,6'h21, 0,8'h00, 8'h3C,8'h30,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,6'h00,8'h00, 0,6'h00, 1,8'h3F, 8'h3C,8'h30,8'h10));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,6'h00,8'h00, 0,6'h00, 1,8'h21, 8'h3C,8'h30,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,6'h00,8'h00, 0,6'h00, 1,8'h3F, 8'h3C,8'h30,8'h10));
        vecs.push_back(mk(0,8'h00,8'h00, 0,8'h00, 0,6'h00,8'h00, 0,6'h00, 1,8'hFF, 8'h3C,8'h30,8'h00));
        vecs.push_back(mk(1,8'h85,8'h3C, 1,8'h85, 0,6'h00,8'h00, 0,6'h00, 0,8'h00, 8'h3C,8'h30,8'h00));
        vecs.push_back(mk(1,8'h10,8'hAA, 1,8'h85, 0,6'h00,8'h00, 0,6'h00, 0,8'h00, 8'h3C,8'h30,8'h00));
        vecs.push_back(mk(0,8'h00,8'h00, 1,8'h10, 0,6'h00,8'h00, 0,6'h00, 0,8'h00, 8'hAA,8'h30,8'h00));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            $display("vec %0d: q=%02h qmax=%02h r=%02h", i, bus.q_rdata, bus.qmax_rdata, bus.r_rdata);
            chk($sformatf("vec%0d_q", i), bus.q_rdata, vecs[i].exp_q);
            chk($sformatf("vec%0d_qmax", i), bus.qmax_rdata, vecs[i].exp_m);
            chk($sformatf("vec%0d_r", i), bus.r_rdata, vecs[i].exp_r);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk($urandom_range(0,1), 8'($urandom), 8'($urandom),
                   $urandom_range(0,1), 8'($urandom),
                   $urandom_range(0,1), 6'($urandom), 8'($urandom),
                   $urandom_range(0,1), 6'($urandom),
                   $urandom_range(0,1), ($urandom_range(0,3) == 0) ? 8'h3F : 8'($urandom),
                   8'h00, 8'h00, 8'h00);
            if (i % 5 == 0) v.q_ra = v.q_wa;
            if (i % 7 == 0) v.m_ra = v.m_wa;
            apply(v);
            $display("rand %0d: q=%02h/%02h qmax=%02h/%02h r=%02h/%02h", i,
                     bus.q_rdata, m_q_out, bus.qmax_rdata, m_qmax_out, bus.r_rdata, m_r_out);
            chk("rand_q", bus.q_rdata, m_q_out);
            chk("rand_qmax", bus.qmax_rdata, m_qmax_out);
            chk("rand_r", bus.r_rdata, m_r_out);
        end

        // Mid-operation reset: outputs drop asynchronously, tables are swept again.
        apply(mk(1,8'h10,8'h55, 0,8'h00, 1,6'h10,8'h44, 0,6'h00, 0,8'h00, 0,0,0));
        apply(mk(0,8'h00,8'h00, 1,8'h10, 0,6'h00,8'h00, 1,6'h10, 1,8'h3F, 0,0,0));
        chk("pre_rst_q", bus.q_rdata, 8'h55);
        chk("pre_rst_qmax", bus.qmax_rdata, 8'h44);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", bus.q_rdata, 8'h00);
        chk("async_rst_qmax", bus.qmax_rdata, 8'h00);
        chk("async_rst_r", bus.r_rdata, 8'h00);
        chk("async_rst_ready", {7'd0, bus.ready}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        // Abort the sweep partway, then a full sweep with strobes that must be ignored.
        repeat (100) cyc();
        rst_n = 1'b0;
        #1;
        chk("midsweep_ready", {7'd0, bus.ready}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check(1'b1);
        wait_ready(10);

        apply(mk(0,8'h00,8'h00, 1,8'h10, 0,6'h00,8'h00, 1,6'h10, 0,8'h00, 0,0,0));
        chk("post_sweep_q10", bus.q_rdata, 8'h00);
        chk("post_sweep_qmax10", bus.qmax_rdata, 8'h00);
        apply(mk(0,8'h00,8'h00, 1,8'h3C, 0,6'h00,8'h00, 1,6'h21, 0,8'h00, 0,0,0));
        chk("post_sweep_q3C", bus.q_rdata, 8'h00);
        chk("post_sweep_qmax21", bus.qmax_rdata, 8'h00);
        apply(mk(0,8'h00,8'h00, 1,8'h05, 0,6'h00,8'h00, 1,6'h02, 1,8'h3F, 0,0,0));
        chk("ignored_q05", bus.q_rdata, 8'h00);
        chk("ignored_qmax02", bus.qmax_rdata, 8'h00);
        chk("post_sweep_r3F", bus.r_rdata, 8'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
